// File: rtl/preg_free_list.sv
// Physical-register free list for the rename stage.
// Hands out one free tag per cycle, reclaims tags released at retire and
// rolls speculative allocations back to the committed head on flush.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    output logic                     alloc_gnt,
    output logic [TAG_W-1:0]         alloc_preg,
    input  logic                     free_valid,
    input  logic [TAG_W-1:0]         free_preg,
    input  logic                     commit_valid,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     empty,
    output logic                     full,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail, chead;
    logic [PW-1:0]    head_n, tail_n, chead_n, count_n;
    logic             push, commit_ok, err_n;

    assign alloc_gnt  = alloc_req & ~empty & ~flush;
    assign alloc_preg = mem[head[AW-1:0]];

    // Next-state pointers; a flush rewinds head to the committed head,
    // including a commit that lands in the same cycle.
    always_comb begin
        push      = free_valid & ~full;
        commit_ok = commit_valid & (chead != head);
        chead_n   = chead + PW'(commit_ok);
        tail_n    = tail + PW'(push);
        head_n    = flush ? chead_n : head + PW'(alloc_gnt);
        count_n   = tail_n - head_n;
        err_n     = err | (free_valid & full) | (commit_valid & (chead == head));
    end

    // Pointer, status and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            chead      <= '0;
            tail       <= PW'(DEPTH);
            free_count <= PW'(DEPTH);
            empty      <= 1'b0;
            full       <= 1'b1;
            err        <= 1'b0;
        end else begin
            head       <= head_n;
            chead      <= chead_n;
            tail       <= tail_n;
            free_count <= count_n;
            empty      <= (count_n == '0);
            full       <= (count_n == PW'(DEPTH));
            err        <= err_n;
        end
    end

    // Tag storage: preloaded with the unmapped tags, written on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= TAG_W'(NUM_AREGS + i);
        end else if (push) begin
            mem[tail[AW-1:0]] <= free_preg;
        end
    end

endmodule
